// File: rtl/cmac_axis_pkt_gen_multi.sv
// -----------------------------------------------------------------------------
// cmac_axis_pkt_gen_multi
// AXI4-Stream packet source for the CMAC TX path. A run is a sequence of
// packets whose size is fixed, sweeps upward by a step, or repeats until
// stopped, with an optional idle gap after each packet. Packet payload
// byte k is (seq + k) mod 256, where seq is the packet's index within the run.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   start, stop            single-cycle control pulses
//   cfg_mode               0 fixed, 1 sweep, 2 continuous, 3 behaves as 0
//   cfg_pkt_num            packets per run (modes 0/1)
//   cfg_pkt_size           initial packet size in bytes (clamped)
//   cfg_size_step          per-packet size increment in sweep mode
//   cfg_gap                idle cycles after each packet
//   m_axis_*               AXI4-Stream master (tuser tied 0)
//   busy, done             run status
//   cfg_err                pulse on start with a zero packet count in mode 0/1
//   pkt_cnt                packets completed this run
// -----------------------------------------------------------------------------
module cmac_axis_pkt_gen_multi #(
    parameter int DATA_W       = 512,
    parameter int SIZE_W       = 14,
    parameter int MIN_PKT_SIZE = 64,
    parameter int MAX_PKT_SIZE = 9600,
    parameter int GAP_W        = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            cfg_mode,
    input  logic [15:0]           cfg_pkt_num,
    input  logic [SIZE_W-1:0]     cfg_pkt_size,
    input  logic [SIZE_W-1:0]     cfg_size_step,
    input  logic [GAP_W-1:0]      cfg_gap,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [15:0]           pkt_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [SIZE_W-1:0] BYTES_S = SIZE_W'(BYTES);
    localparam logic [SIZE_W-1:0] MIN_S   = SIZE_W'(MIN_PKT_SIZE);
    localparam logic [SIZE_W-1:0] MAX_S   = SIZE_W'(MAX_PKT_SIZE);
    localparam logic [SIZE_W:0]   MAX_W   = (SIZE_W+1)'(MAX_PKT_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [15:0]         num_q;
    logic [SIZE_W-1:0]   base_q;     // clamped initial size, sweep reload value
    logic [SIZE_W-1:0]   size_q;     // size of the packet being sent
    logic [SIZE_W-1:0]   step_q;
    logic [GAP_W-1:0]    gap_q;
    logic [GAP_W-1:0]    gap_cnt;
    logic [7:0]          seq_q;
    logic [SIZE_W-1:0]   off_q;      // byte offset of the beat on the bus
    logic                stop_q;
    logic                tvalid_q;
    logic                busy_q;
    logic                done_q;
    logic                cfg_err_q;
    logic [15:0]         pkt_cnt_q;

    logic [1:0]          mode_eff;
    logic                cfg_bad;
    logic [SIZE_W-1:0]   size_clamped;
    logic [SIZE_W-1:0]   rem;
    logic                last_beat;
    logic                xfer;
    logic                stop_any;
    logic [15:0]         pkt_cnt_inc;
    logic                run_end;
    logic [SIZE_W:0]     sweep_sum;
    logic [SIZE_W-1:0]   sweep_next;

    always_comb begin
        mode_eff     = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
        cfg_bad      = (mode_eff != 2'd2) && (cfg_pkt_num == 16'd0);
        size_clamped = (cfg_pkt_size < MIN_S) ? MIN_S :
                       (cfg_pkt_size > MAX_S) ? MAX_S : cfg_pkt_size;
        rem          = size_q - off_q;
        last_beat    = (rem <= BYTES_S);
        xfer         = tvalid_q && m_axis_tready;
        // a stop arriving on the tlast cycle itself also ends the run
        stop_any     = stop_q || stop;
        pkt_cnt_inc  = pkt_cnt_q + 16'd1;
        run_end      = stop_any || ((mode_q != 2'd2) && (pkt_cnt_inc == num_q));
        sweep_sum    = {1'b0, size_q} + {1'b0, step_q};
        sweep_next   = (sweep_sum > MAX_W) ? base_q : sweep_sum[SIZE_W-1:0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            num_q     <= '0;
            base_q    <= '0;
            size_q    <= '0;
            step_q    <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            seq_q     <= '0;
            off_q     <= '0;
            stop_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            if (stop && (state == S_LOAD || state == S_SEND || state == S_GAP))
                stop_q <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            state  <= S_LOAD;
                            busy_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    mode_q    <= mode_eff;
                    num_q     <= cfg_pkt_num;
                    base_q    <= size_clamped;
                    size_q    <= size_clamped;
                    step_q    <= cfg_size_step;
                    gap_q     <= cfg_gap;
                    pkt_cnt_q <= '0;
                    done_q    <= 1'b0;
                    seq_q     <= '0;
                    off_q     <= '0;
                    stop_q    <= stop;   // drop any stale stop, keep a fresh one
                    tvalid_q  <= 1'b1;
                    state     <= S_SEND;
                end

                S_SEND: begin
                    if (xfer) begin
                        if (last_beat) begin
                            pkt_cnt_q <= pkt_cnt_inc;
                            seq_q     <= seq_q + 8'd1;
                            off_q     <= '0;
                            if (mode_q == 2'd1)
                                size_q <= sweep_next;
                            if (run_end) begin
                                tvalid_q <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                state    <= S_DONE;
                            end else if (gap_q != '0) begin
                                tvalid_q <= 1'b0;
                                gap_cnt  <= gap_q;
                                state    <= S_GAP;
                            end
                            // otherwise tvalid stays high: back-to-back packets
                        end else begin
                            off_q <= off_q + BYTES_S;
                        end
                    end
                end

                S_GAP: begin
                    if (stop_any) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                        // raise tvalid on the last idle cycle so the gap is exact
                        if (gap_cnt == GAP_W'(1)) begin
                            tvalid_q <= 1'b1;
                            state    <= S_SEND;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Beat contents derive from registered state only; gating with tvalid
    // keeps the bus at zero while idle and during reset.
    for (genvar i = 0; i < BYTES; i++) begin : g_byte
        localparam logic [7:0]        IDX   = 8'(i % 256);
        localparam logic [SIZE_W-1:0] IDX_S = SIZE_W'(i);
        assign m_axis_tkeep[i]        = tvalid_q && (!last_beat || (IDX_S < rem));
        assign m_axis_tdata[8*i +: 8] = m_axis_tkeep[i] ? (seq_q + off_q[7:0] + IDX) : 8'h00;
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q && last_beat;
    assign m_axis_tuser  = 1'b0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
